// File: rtl/pipe_pkg.sv
// Shared constants for the EXE/MEM/WB stage registers: occupancy state encoding
// and the per-stage payload field widths used to size each stage's DATA_W.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    localparam int WRID_W    = 5;
    localparam int FMASK_W   = 8;
    localparam int MEMCTRL_W = 7;
    localparam int FLAGS_W   = 8;
    localparam int WORD_W    = 16;

    // Payload widths of the concrete stage boundaries, built from the fields above.
    localparam int EXE_MEM_W = WRID_W + FMASK_W + MEMCTRL_W + FLAGS_W + 2 * WORD_W;
    localparam int MEM_WB_W  = WRID_W + FMASK_W + FLAGS_W + WORD_W;

    function automatic int stage_payload_w(input bit exe_to_mem);
        return exe_to_mem ? EXE_MEM_W : MEM_WB_W;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with a variable increment and asynchronous active-low clear.
module sat_counter #(
    parameter int W     = 16,
    parameter int INC_W = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             en,
    input  logic [INC_W-1:0] inc,
    output logic [W-1:0]     count
);

    logic [W-1:0] count_reg;
    logic [W:0]   sum_next;

    // One guard bit catches the wrap; inc never exceeds the counter range.
    assign sum_next = {1'b0, count_reg} + (W+1)'(inc);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= sum_next[W] ? {W{1'b1}} : sum_next[W-1:0];
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid buffer,
// stall-over-flush control and saturating stall/drop debug counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W       = 64,
    parameter int SKID_EN      = 1,
    parameter int CLR_ON_FLUSH = 1,
    parameter int CNT_W        = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              stall,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [7:0]        drop_cnt
);

    state_t            state_reg;
    logic [DATA_W-1:0] main_d_reg;
    logic [DATA_W-1:0] skid_q;
    logic              main_v;
    logic              skid_v;
    logic              room;
    logic              acc;
    logic              dep;
    logic              flush_eff;

    assign main_v = (state_reg != ST_EMPTY);
    assign skid_v = (state_reg == ST_TWO);

    // With the skid present, readiness depends only on local state, never on out_ready.
    assign room = (SKID_EN != 0) ? !skid_v : (!main_v || out_ready);

    assign in_ready  = RST_N && !stall && !flush && room;
    assign out_valid = main_v && !stall && !flush;
    assign out_data  = main_d_reg;
    assign occupancy = state_reg;

    assign acc       = in_valid && in_ready;
    assign dep       = out_valid && out_ready;
    assign flush_eff = flush && !stall;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg  <= ST_EMPTY;
            main_d_reg <= '0;
        end else if (!stall) begin
            if (flush) begin
                state_reg <= ST_EMPTY;
                if (CLR_ON_FLUSH != 0) begin
                    main_d_reg <= '0;
                end
            end else begin
                case (state_reg)
                    ST_EMPTY: begin
                        if (acc) begin
                            state_reg  <= ST_ONE;
                            main_d_reg <= in_data;
                        end
                    end
                    ST_ONE: begin
                        if (acc && dep) begin
                            main_d_reg <= in_data;
                        end else if (acc && (SKID_EN != 0)) begin
                            state_reg <= ST_TWO;
                        end else if (dep) begin
                            state_reg <= ST_EMPTY;
                        end
                    end
                    ST_TWO: begin
                        if (dep) begin
                            state_reg  <= ST_ONE;
                            main_d_reg <= skid_q;
                        end
                    end
                    default: state_reg <= ST_EMPTY;
                endcase
            end
        end
    end

    generate
        if (SKID_EN != 0) begin : g_skid
            logic [DATA_W-1:0] skid_d_reg;

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    skid_d_reg <= '0;
                end else if (!stall) begin
                    if (flush) begin
                        if (CLR_ON_FLUSH != 0) begin
                            skid_d_reg <= '0;
                        end
                    end else if ((state_reg == ST_ONE) && acc && !dep) begin
                        skid_d_reg <= in_data;
                    end
                end
            end

            assign skid_q = skid_d_reg;
        end else begin : g_no_skid
            assign skid_q = '0;
        end
    endgenerate

    sat_counter #(
        .W     (CNT_W),
        .INC_W (1)
    ) u_stall_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .en    (stall && main_v),
        .inc   (1'b1),
        .count (stall_cnt)
    );

    // A flush drops exactly the beats held at that edge.
    sat_counter #(
        .W     (8),
        .INC_W (2)
    ) u_drop_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .en    (flush_eff),
        .inc   (occupancy),
        .count (drop_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance and a single-entry instance share stimulus
// and are checked every cycle against a queue-based model, plus literal directed checks.
module tb_pipe_stage_reg;

    localparam int DW = 16;
    localparam int CW = 4;
    localparam int SMAX = (1 << CW) - 1;

    logic          CLK;
    logic          RST_N;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          stall;
    logic          flush;

    logic [1:0]    in_ready_w;
    logic [1:0]    out_valid_w;
    logic [DW-1:0] out_data_w [2];
    logic [1:0]    occ_w [2];
    logic [CW-1:0] scnt_w [2];
    logic [7:0]    dcnt_w [2];

    pipe_stage_reg #(.DATA_W(DW), .SKID_EN(1), .CLR_ON_FLUSH(1), .CNT_W(CW)) dut_a (
        .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .in_data(in_data), .out_valid(out_valid_w[0]), .out_ready(out_ready),
        .out_data(out_data_w[0]), .stall(stall), .flush(flush),
        .occupancy(occ_w[0]), .stall_cnt(scnt_w[0]), .drop_cnt(dcnt_w[0])
    );

    pipe_stage_reg #(.DATA_W(DW), .SKID_EN(0), .CLR_ON_FLUSH(0), .CNT_W(CW)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .in_data(in_data), .out_valid(out_valid_w[1]), .out_ready(out_ready),
        .out_data(out_data_w[1]), .stall(stall), .flush(flush),
        .occupancy(occ_w[1]), .stall_cnt(scnt_w[1]), .drop_cnt(dcnt_w[1])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: per instance a FIFO of held beats, last payload seen at the head, counters.
    int            m_cap  [2] = '{2, 1};
    bit            m_clr  [2] = '{1'b1, 1'b0};
    int            m_cnt  [2];
    logic [DW-1:0] m_buf  [2][2];
    logic [DW-1:0] m_hold [2];
    int            m_scnt [2];
    int            m_dcnt [2];

    bit            mon_en = 1'b0;
    logic [DW-1:0] mon_exp [2];
    int            mon_cnt [2];

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", name, k, act, exp, $time);
        end
    endtask

    function automatic bit m_in_ready(input int k);
        if (!RST_N || stall || flush) return 1'b0;
        if (m_cap[k] == 2) return m_cnt[k] < 2;
        return (m_cnt[k] == 0) || out_ready;
    endfunction

    function automatic bit m_out_valid(input int k);
        return (m_cnt[k] > 0) && !stall && !flush;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_hold[k] = '0; m_scnt[k] = 0; m_dcnt[k] = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit acc;
            bit dep;
            if (!RST_N) begin
                m_cnt[k] = 0; m_hold[k] = '0; m_scnt[k] = 0; m_dcnt[k] = 0;
                continue;
            end
            acc = in_valid && m_in_ready(k);
            dep = m_out_valid(k) && out_ready;
            if (stall) begin
                if (m_cnt[k] != 0 && m_scnt[k] < SMAX) m_scnt[k]++;
            end else if (flush) begin
                m_dcnt[k] = (m_dcnt[k] + m_cnt[k] > 255) ? 255 : m_dcnt[k] + m_cnt[k];
                m_cnt[k] = 0;
                if (m_clr[k]) m_hold[k] = '0;
            end else begin
                if (dep) begin
                    m_buf[k][0] = m_buf[k][1];
                    m_cnt[k]--;
                end
                if (acc) begin
                    m_buf[k][m_cnt[k]] = in_data;
                    m_cnt[k]++;
                end
            end
            if (m_cnt[k] > 0) m_hold[k] = m_buf[k][0];
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            chk("in_ready",  k, 32'(in_ready_w[k]),  32'(m_in_ready(k)));
            chk("out_valid", k, 32'(out_valid_w[k]), 32'(m_out_valid(k)));
            chk("out_data",  k, 32'(out_data_w[k]),  32'(m_hold[k]));
            chk("occupancy", k, 32'(occ_w[k]),       32'(m_cnt[k]));
            chk("stall_cnt", k, 32'(scnt_w[k]),      32'(m_scnt[k]));
            chk("drop_cnt",  k, 32'(dcnt_w[k]),      32'(m_dcnt[k]));
            if (mon_en && out_valid_w[k] && out_ready) begin
                chk("seq", k, 32'(out_data_w[k]), 32'(mon_exp[k]));
                mon_exp[k]++;
                mon_cnt[k]++;
            end
        end
    endtask

    // Check mid-cycle, then advance model on the edge; returns just after the edge.
    task automatic cycle();
        @(negedge CLK);
        compare_all();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        model_reset();
        cycle();
        cycle();
        RST_N = 1'b1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        cycle();
        in_valid = 1'b0;
        $display("[TB] push 0x%0h -> occupancy %0d/%0d", d, occ_w[0], occ_w[1]);
    endtask

    initial begin
        idle_inputs();
        RST_N = 1'b1;
        #1;
        do_reset();

        // 1: single beat, then reset in the middle of a transfer
        out_ready = 1'b1;
        push(16'hA5);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("t1_valid", k, 32'(out_valid_w[k]), 32'd1);
            chk("t1_data",  k, 32'(out_data_w[k]),  32'hA5);
            chk("t1_occ",   k, 32'(occ_w[k]),       32'd1);
        end
        in_valid = 1'b1; in_data = 16'h5A;
        RST_N = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("t1_rst_valid", k, 32'(out_valid_w[k]), 32'd0);
            chk("t1_rst_data",  k, 32'(out_data_w[k]),  32'd0);
            chk("t1_rst_occ",   k, 32'(occ_w[k]),       32'd0);
            chk("t1_rst_rdy",   k, 32'(in_ready_w[k]),  32'd0);
        end
        $display("[TB] async reset mid-transfer");
        cycle();
        RST_N = 1'b1;
        idle_inputs();
        cycle();

        // 2/3: fill the skid, flush it, then refill and drain in order
        push(16'h11);
        push(16'h22);
        #1;
        chk("t2_occ", 0, 32'(occ_w[0]),      32'd2);
        chk("t2_rdy", 0, 32'(in_ready_w[0]), 32'd0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        #1;
        chk("t3_occ",   0, 32'(occ_w[0]),       32'd0);
        chk("t3_valid", 0, 32'(out_valid_w[0]), 32'd0);
        chk("t3_drop",  0, 32'(dcnt_w[0]),      32'd2);
        chk("t3_data",  0, 32'(out_data_w[0]),  32'd0);
        $display("[TB] flush with two held beats");
        push(16'h11);
        push(16'h22);
        out_ready = 1'b1;
        #1;
        chk("t2_first", 0, 32'(out_data_w[0]), 32'h11);
        cycle();
        chk("t2_second", 0, 32'(out_data_w[0]), 32'h22);
        cycle();
        chk("t2_empty", 0, 32'(occ_w[0]), 32'd0);
        $display("[TB] drained 0x11, 0x22");

        // 4: stall beats flush; 6: stall counter saturation
        do_reset();
        push(16'h33);
        stall = 1'b1; flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_valid", 0, 32'(out_valid_w[0]), 32'd0);
            chk("t4_rdy",   0, 32'(in_ready_w[0]),  32'd0);
            cycle();
        end
        stall = 1'b0; flush = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("t4_scnt",  k, 32'(scnt_w[k]),      32'd3);
            chk("t4_drop",  k, 32'(dcnt_w[k]),      32'd0);
            chk("t4_occ",   k, 32'(occ_w[k]),       32'd1);
            chk("t4_valid", k, 32'(out_valid_w[k]), 32'd1);
            chk("t4_data",  k, 32'(out_data_w[k]),  32'h33);
        end
        $display("[TB] stall+flush x3 held beat 0x33");
        stall = 1'b1;
        for (int i = 0; i < (1 << CW) + 5; i++) cycle();
        stall = 1'b0;
        #1;
        chk("t6_scnt_sat", 0, 32'(scnt_w[0]), 32'd15);
        out_ready = 1'b1;
        cycle();
        chk("t6_drained", 0, 32'(occ_w[0]), 32'd0);
        $display("[TB] stall_cnt saturated, beat 0x33 emitted");

        // 5: back-to-back streaming 1..100
        do_reset();
        for (int k = 0; k < 2; k++) begin
            mon_exp[k] = 16'd1; mon_cnt[k] = 0;
        end
        mon_en = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            in_data = 16'(i);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        mon_en = 1'b0;
        for (int k = 0; k < 2; k++) chk("t5_beats", k, 32'(mon_cnt[k]), 32'd100);
        $display("[TB] streamed 100 beats: %0d/%0d out", mon_cnt[0], mon_cnt[1]);

        // Random traffic, stalls and flushes against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
            stall     = ($urandom_range(0, 9) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            cycle();
        end
        idle_inputs();
        cycle();
        $display("[TB] random phase done, drop_cnt %0d/%0d", dcnt_w[0], dcnt_w[1]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register that replaces the fixed-field per-stage latches between EXE, MEM and WB. The payload is carried as one opaque vector, and each stage packs its own fields into it. The block adds a valid/ready handshake, an optional 2-entry skid buffer so that in_ready is not combinational on out_ready, and flush/stall semantics where stall overrides flush. Saturating occupancy and perf counters support debug.

Parameters:
DATA_W, 64, payload width in bits (1..256)
SKID_EN, 1, 1 = 2-entry skid (registered-ready path); 0 = single entry with in_ready combinational on out_ready
CLR_ON_FLUSH, 1, 1 = payload registers zeroed on flush; 0 = only valid bits cleared
CNT_W, 16, width of the stall-cycle counter

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
in_valid  in  1  upstream beat present
in_ready  out  1  stage accepts a beat this cycle
in_data  in  DATA_W  upstream payload
out_valid  out  1  stage presents a beat downstream
out_ready  in  1  downstream accepts
out_data  out  DATA_W  payload of the oldest held beat
stall  in  1  freeze stage; overrides flush
flush  in  1  discard all held beats
occupancy  out  2  number of valid entries (0..2)
stall_cnt  out  CNT_W  saturating count of cycles with stall=1 and occupancy!=0
drop_cnt  out  8  saturating count of beats discarded by flush

Behaviour:
- Reset (RST_N=0, asynchronous, takes effect mid-operation): all valid bits, payload registers and counters go to 0, so out_valid=0, out_data=0, occupancy=0, stall_cnt=0, drop_cnt=0. in_ready=0 while RST_N=0.
- Combinational outputs:
  - in_ready = !stall & !flush & (SKID_EN ? !skid_v : (!main_v | out_ready))
  - out_valid = main_v & !stall & !flush
  - out_data = main_d
- Transfers: acc = in_valid & in_ready; dep = out_valid & out_ready. Payload only moves on acc/dep. Order is strictly FIFO.
- States with SKID_EN=1 (encoding EMPTY=0, ONE=1, TWO=2; occupancy = state):
  - EMPTY: acc -> ONE, main<=in_data.
  - ONE: acc&dep -> ONE, main<=in_data. acc&!dep -> TWO, skid<=in_data. dep&!acc -> EMPTY.
  - TWO: in_ready=0. dep -> ONE, main<=skid.
- With SKID_EN=0: only the EMPTY and ONE states exist, and skid registers are not generated. ONE with acc&dep -> ONE.
- Stall=1: all state and payload hold, including when flush=1 the same cycle. The flush is dropped, not deferred.
- Flush=1 & stall=0: the next state is EMPTY. drop_cnt += occupancy (saturate at 255). No acc or dep occurs that cycle. If CLR_ON_FLUSH=1, main_d and skid_d <= 0.
- stall_cnt increments on each cycle with stall=1 & occupancy!=0 and saturates at all-ones.
- Latency: 1 cycle from acc to out_valid when empty. Throughput is 1 beat/cycle under continuous out_ready.
- No X on outputs after reset. in_data is ignored when acc=0.

Decomposition:
- Shared package pipe_pkg holds:
  - state localparams ST_EMPTY/ST_ONE/ST_TWO
  - the per-stage payload field-width constants (WRID_W=5, FMASK_W=8, MEMCTRL_W=7, FLAGS_W=8, WORD_W=16), used by stage wrappers to size DATA_W.
- One sub-module, sat_counter (parametrised width, inc amount, async active-low clear), is instantiated for both stall_cnt and drop_cnt.

Test Plan:
1. Reset then push 0xA5 with out_ready=1 -> out_valid the next cycle, out_data=0xA5, occupancy=1. Assert RST_N=0 mid-transfer -> all outputs 0 immediately.
2. SKID_EN=1, out_ready=0, push 0x11 then 0x22 -> occupancy=2 and in_ready=0. Raise out_ready -> 0x11 then 0x22 emitted in order.
3. Occupancy=2, flush=1 for one cycle -> occupancy=0, out_valid=0, drop_cnt=2, out_data=0 (CLR_ON_FLUSH=1).
4. Occupancy=1, stall=1 and flush=1 together for 3 cycles -> contents kept, out_valid=0, in_ready=0, stall_cnt=3, drop_cnt=0. Release -> original beat emitted.
5. Continuous in_valid=1, out_ready=1 with beats 1..100 -> one beat/cycle, no loss or duplication. Repeat with SKID_EN=0 and random out_ready.
6. Hold stall with occupancy=1 for 2^CNT_W+5 cycles (CNT_W=4) -> stall_cnt saturates at 15.
